// File: rtl/custom_01_pkg.sv
// Shared types and helpers for the nibble packer: data widths, packer phase
// encoding and the mapping of upstream mux-stage bits onto one nibble.
package custom_01_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } pack_phase_e;

    // Upstream t_o_a/t_o_b/t_o_c land as {c[1], c[0], b, a}.
    function automatic logic [NIBBLE_W-1:0] pack_nibble(
        input logic       a,
        input logic       b,
        input logic [1:0] c
    );
        return {c[1], c[0], b, a};
    endfunction

endpackage

// File: rtl/custom_01_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. A push into a full FIFO is
// accepted only when a pop frees the head slot on the same edge.
module custom_01_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      level_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign level = level_q;

    a_level_tracks_ptrs: assert property (
        @(posedge clk) disable iff (!rst_n) level_q == (wr_ptr_q - rd_ptr_q)
    );

    a_level_bounded: assert property (
        @(posedge clk) disable iff (!rst_n) level_q <= (AW + 1)'(DEPTH)
    );

endmodule

// File: rtl/custom_01_nibble_packer.sv
// Packs pairs of enabled 4-bit samples into bytes (first nibble low), queues
// them in a small FIFO, and counts bytes dropped because the FIFO was full.
module custom_01_nibble_packer
    import custom_01_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     t_i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_a,
    input  logic                     i_b,
    input  logic [1:0]               i_c,
    output logic [BYTE_W-1:0]        o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [CNT_W-1:0]         o_drop_cnt,
    output logic                     o_ovf,
    input  logic                     i_clr_ovf,
    output pack_phase_e              o_phase
);

    // Handshake: a byte leaves the FIFO on an edge where o_valid and i_ready
    // are both 1; o_data is stable while o_valid is 1 and i_ready is 0.

    pack_phase_e         phase_q, phase_d;
    logic [NIBBLE_W-1:0] lo_q, lo_d;
    logic [NIBBLE_W-1:0] nibble;
    logic [BYTE_W-1:0]   push_byte;
    logic                push_req;

    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_fire;
    logic                drop;

    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                ovf_q, ovf_d;

    assign nibble    = pack_nibble(i_a, i_b, i_c);
    assign push_byte = {nibble, lo_q};

    always_ff @(posedge t_i_clk) begin
        if (!i_rst) begin
            phase_q <= PH_LO;
            lo_q    <= '0;
        end else begin
            phase_q <= phase_d;
            lo_q    <= lo_d;
        end
    end

    // A half byte waits in lo_q for as long as it takes; there is no timeout.
    always_comb begin
        phase_d  = phase_q;
        lo_d     = lo_q;
        push_req = 1'b0;
        if (i_en) begin
            case (phase_q)
                PH_LO: begin
                    lo_d    = nibble;
                    phase_d = PH_HI;
                end
                PH_HI: begin
                    push_req = 1'b1;
                    phase_d  = PH_LO;
                end
                default: phase_d = PH_LO;
            endcase
        end
    end

    custom_01_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (t_i_clk),
        .rst_n (i_rst),
        .push  (push_req),
        .wdata (push_byte),
        .pop   (i_ready),
        .rdata (o_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    assign o_valid  = ~fifo_empty;
    assign pop_fire = o_valid & i_ready;
    assign drop     = push_req & fifo_full & ~pop_fire;

    // A drop on the clearing edge still counts, so the counter restarts at 1.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (i_clr_ovf) begin
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (i_clr_ovf) begin
                drop_cnt_d = CNT_W'(1);
            end else if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge t_i_clk) begin
        if (!i_rst) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
    assign o_ovf      = ovf_q;
    assign o_phase    = phase_q;

    a_drop_only_when_full: assert property (
        @(posedge t_i_clk) disable iff (!i_rst) drop |-> fifo_full
    );

endmodule
